// File: rtl/window_pulse_gen_multi.sv
// Free-running period counter driving NUM_CH windowed clock/strobe outputs; window config is
// double-buffered and applied only at wrap. Define WINDOW_PULSE_GEN_CFG_ERR_EN to add cfg_err.
module window_pulse_gen_multi #(
  parameter int unsigned       WIDTH    = 32,
  parameter int unsigned       NUM_CH   = 4,
  parameter logic [NUM_CH-1:0] INV_MASK = '0,
  localparam int unsigned      CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [WIDTH-1:0]  period,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]  cfg_lower,
  input  logic [WIDTH-1:0]  cfg_upper,
  input  logic              cfg_invert,
`ifdef WINDOW_PULSE_GEN_CFG_ERR_EN
  output logic              cfg_err,
`endif
  output logic [WIDTH-1:0]  counter_out,
  output logic              wrap,
  output logic [NUM_CH-1:0] out
);

  logic [WIDTH-1:0]  counter_q, counter_d;
  logic [WIDTH-1:0]  last_count;
  logic              at_last;
  logic              wr_accept;
  logic [NUM_CH-1:0] wr_sel;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] out_q, out_d;

  logic [WIDTH-1:0]  pend_lower_q [NUM_CH];
  logic [WIDTH-1:0]  pend_upper_q [NUM_CH];
  logic [WIDTH-1:0]  act_lower_q  [NUM_CH];
  logic [WIDTH-1:0]  act_upper_q  [NUM_CH];
  logic [NUM_CH-1:0] pend_inv_q, act_inv_q;

  // period 0 behaves as period 1, so the terminal count is 0 in both cases
  assign last_count = (period == '0) ? '0 : period - WIDTH'(1);
  // >= rather than == so a shrinking period wraps on the next enabled cycle
  assign at_last    = counter_q >= last_count;
  assign wrap       = enable & at_last;

  always_comb begin
    counter_d = counter_q;
    if (enable) begin
      counter_d = at_last ? '0 : counter_q + WIDTH'(1);
    end
  end

  // Out-of-range channels keep the default ready so their writes drain harmlessly
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = ~pend_q[i];
      end
    end
  end

  assign wr_accept = cfg_valid & cfg_ready;

  always_comb begin
    wr_sel = '0;
    out_d  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = wr_accept & (cfg_ch == CH_W'(i));
      out_d[i]  = ((counter_q > act_lower_q[i]) && (counter_q <= act_upper_q[i])) ^ act_inv_q[i];
    end
  end

  // A wrap clears pend, but a write landing in the same cycle re-arms it for the next wrap
  assign pend_d = wr_sel | (pend_q & ~{NUM_CH{wrap}});

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_q  <= '0;
      pend_q     <= '0;
      out_q      <= INV_MASK;
      pend_inv_q <= INV_MASK;
      act_inv_q  <= INV_MASK;
      for (int i = 0; i < NUM_CH; i++) begin
        pend_lower_q[i] <= '0;
        pend_upper_q[i] <= '0;
        act_lower_q[i]  <= '0;
        act_upper_q[i]  <= '0;
      end
    end else begin
      counter_q <= counter_d;
      pend_q    <= pend_d;
      out_q     <= out_d;
      for (int i = 0; i < NUM_CH; i++) begin
        if (wrap && pend_q[i]) begin
          act_lower_q[i] <= pend_lower_q[i];
          act_upper_q[i] <= pend_upper_q[i];
          act_inv_q[i]   <= pend_inv_q[i];
        end
        if (wr_sel[i]) begin
          pend_lower_q[i] <= cfg_lower;
          pend_upper_q[i] <= cfg_upper;
          pend_inv_q[i]   <= cfg_invert;
        end
      end
    end
  end

  assign counter_out = counter_q;
  assign out         = out_q;

`ifdef WINDOW_PULSE_GEN_CFG_ERR_EN
  logic ch_valid;
  logic err_q;

  always_comb begin
    ch_valid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        ch_valid = 1'b1;
      end
    end
  end

  // Sticky until reset; the offending write is still taken
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (wr_accept &&
                 ((cfg_lower >= cfg_upper) || (cfg_upper >= period) || !ch_valid)) begin
      err_q <= 1'b1;
    end
  end

  assign cfg_err = err_q;
`endif

endmodule

// File: tb/tb_window_pulse_gen_multi.sv
// Randomized and directed bench for window_pulse_gen_multi against a per-cycle reference model.
module tb_window_pulse_gen_multi;

  localparam int W   = 8;
  localparam int NCH = 3;
  localparam int CHW = 2;
  localparam logic [NCH-1:0] INV = 3'b010;

  logic           clk = 1'b0;
  logic           reset, enable, cfg_valid, cfg_ready, cfg_invert, wrap;
  logic [W-1:0]   period, cfg_lower, cfg_upper, counter_out;
  logic [CHW-1:0] cfg_ch;
  logic [NCH-1:0] out;
`ifdef WINDOW_PULSE_GEN_CFG_ERR_EN
  logic           cfg_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int             m_cnt;
  int             m_plo [NCH];
  int             m_pup [NCH];
  int             m_alo [NCH];
  int             m_aup [NCH];
  bit             m_pinv[NCH];
  bit             m_ainv[NCH];
  bit             m_pend[NCH];
  logic [NCH-1:0] m_out;
  bit             m_err;

  always #5 clk = ~clk;

  window_pulse_gen_multi #(
    .WIDTH    (W),
    .NUM_CH   (NCH),
    .INV_MASK (INV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .period      (period),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_lower   (cfg_lower),
    .cfg_upper   (cfg_upper),
    .cfg_invert  (cfg_invert),
`ifdef WINDOW_PULSE_GEN_CFG_ERR_EN
    .cfg_err     (cfg_err),
`endif
    .counter_out (counter_out),
    .wrap        (wrap),
    .out         (out)
  );

  function automatic int eff_period();
    return (period == 0) ? 1 : int'(period);
  endfunction

  // The counter sits on its last value (or beyond, after a period shrink) when it wraps
  function automatic bit m_wrap();
    return enable && (m_cnt >= eff_period() - 1);
  endfunction

  function automatic bit m_ready();
    if (int'(cfg_ch) >= NCH) return 1'b1;
    return !m_pend[int'(cfg_ch)];
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_err = 1'b0;
    m_out = INV;
    for (int i = 0; i < NCH; i++) begin
      m_plo[i] = 0; m_pup[i] = 0; m_alo[i] = 0; m_aup[i] = 0;
      m_pinv[i] = INV[i]; m_ainv[i] = INV[i]; m_pend[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit w, acc;
    int ch;
    logic [NCH-1:0] nxt;
    if (reset) begin
      model_reset();
      return;
    end
    w   = m_wrap();
    acc = cfg_valid && m_ready();
    ch  = int'(cfg_ch);
    for (int i = 0; i < NCH; i++)
      nxt[i] = ((m_cnt > m_alo[i]) && (m_cnt <= m_aup[i])) ^ m_ainv[i];
    if (w) begin
      for (int i = 0; i < NCH; i++) begin
        if (m_pend[i]) begin
          m_alo[i] = m_plo[i]; m_aup[i] = m_pup[i]; m_ainv[i] = m_pinv[i];
          m_pend[i] = 1'b0;
        end
      end
    end
    if (acc) begin
      if (ch < NCH) begin
        m_plo[ch] = int'(cfg_lower); m_pup[ch] = int'(cfg_upper); m_pinv[ch] = cfg_invert;
        m_pend[ch] = 1'b1;
      end
      if (cfg_lower >= cfg_upper || cfg_upper >= period || ch >= NCH) m_err = 1'b1;
    end
    m_out = nxt;
    if (enable) m_cnt = w ? 0 : m_cnt + 1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    cfg_valid = 1'b0; cfg_ch = '0; cfg_lower = '0; cfg_upper = '0; cfg_invert = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; period = 8'd10;
    set_idle();
    #1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; period = 8'd10;
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_lower = 8'd1; cfg_upper = 8'd4; cfg_invert = 1'b1;
    #1;
    tick();
    reset = 1'b0; enable = 1'b0;
    set_idle();
    #1;
    n_cmp++; if (counter_out !== 8'd0) begin n_bad++;
      $display("FAIL reset_counter: got %0d expected 0", counter_out); end
    n_cmp++; if (wrap !== 1'b0) begin n_bad++;
      $display("FAIL reset_wrap: got %b expected 0", wrap); end
    n_cmp++; if (out !== 3'b010) begin n_bad++;
      $display("FAIL reset_out: got %b expected 010", out); end
`ifdef WINDOW_PULSE_GEN_CFG_ERR_EN
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++;
      $display("FAIL reset_cfg_err: got %b expected 0", cfg_err); end
`endif
    for (int c = 0; c < 4; c++) begin
      cfg_ch = 2'(c);
      #1;
      n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++;
        $display("FAIL reset_ready ch%0d: got %b expected 1", c, cfg_ready); end
    end
    cfg_ch = '0;
    tick();
  endtask

  task automatic test_window();
    bit seen_wrap = 1'b0;
    int pc = 0;
    do_reset();
    enable = 1'b1; period = 8'd10;
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_lower = 8'd2; cfg_upper = 8'd5;
    #1;
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++;
      $display("FAIL window_ready: got %b expected 1", cfg_ready); end
    tick();
    set_idle();
    for (int k = 0; k < 30; k++) begin
      #1;
      n_cmp++; if (counter_out !== W'(m_cnt)) begin n_bad++;
        $display("FAIL window_counter: got %0d expected %0d", counter_out, m_cnt); end
      n_cmp++; if (wrap !== m_wrap()) begin n_bad++;
        $display("FAIL window_wrap: got %b expected %b", wrap, m_wrap()); end
      n_cmp++; if (out !== m_out) begin n_bad++;
        $display("FAIL window_out: got %b expected %b", out, m_out); end
      if (seen_wrap) begin
        n_cmp++; if (out[0] !== (pc >= 3 && pc <= 5)) begin n_bad++;
          $display("FAIL window_ch0 prev_count=%0d: got %b expected %b", pc, out[0],
                   (pc >= 3 && pc <= 5)); end
      end
      if (m_wrap()) begin
        n_cmp++; if (counter_out !== 8'd9) begin n_bad++;
          $display("FAIL window_wrap_at: got %0d expected 9", counter_out); end
        seen_wrap = 1'b1;
      end
      pc = m_cnt;
      tick();
    end
  endtask

  task automatic test_invert();
    do_reset();
    enable = 1'b1; period = 8'd10;
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_lower = 8'd2; cfg_upper = 8'd5; cfg_invert = 1'b0;
    #1;
    tick();
    cfg_ch = 2'd1; cfg_invert = 1'b1;
    #1;
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++;
      $display("FAIL invert_ready: got %b expected 1", cfg_ready); end
    tick();
    set_idle();
    for (int k = 0; k < 25; k++) begin
      #1;
      n_cmp++; if (out !== m_out) begin n_bad++;
        $display("FAIL invert_out: got %b expected %b", out, m_out); end
      n_cmp++; if (out[1] !== ~out[0]) begin n_bad++;
        $display("FAIL invert_pair: got out1=%b out0=%b expected complements", out[1], out[0]); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int  stalls = 0;
    bit  done = 1'b0;
    do_reset();
    enable = 1'b1; period = 8'd10;
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_lower = 8'd1; cfg_upper = 8'd3;
    #1;
    tick();
    cfg_lower = 8'd4; cfg_upper = 8'd8;
    for (int k = 0; k < 30 && !done; k++) begin
      #1;
      n_cmp++; if (cfg_ready !== m_ready()) begin n_bad++;
        $display("FAIL b2b_ready: got %b expected %b", cfg_ready, m_ready()); end
      if (m_ready()) done = 1'b1;
      else stalls++;
      tick();
    end
    set_idle();
    n_cmp++; if (!done) begin n_bad++;
      $display("FAIL b2b_timeout: got no accept expected accept within 30 cycles"); end
    n_cmp++; if (stalls != 9) begin n_bad++;
      $display("FAIL b2b_stalls: got %0d expected 9", stalls); end
    for (int k = 0; k < 25; k++) begin
      #1;
      n_cmp++; if (out !== m_out) begin n_bad++;
        $display("FAIL b2b_out: got %b expected %b", out, m_out); end
      tick();
    end
  endtask

  task automatic test_write_at_wrap();
    bit found = 1'b0;
    do_reset();
    enable = 1'b1; period = 8'd6;
    for (int k = 0; k < 10 && !found; k++) begin
      #1;
      if (m_wrap()) found = 1'b1;
      else tick();
    end
    n_cmp++; if (!found) begin n_bad++;
      $display("FAIL waw_find_wrap: got none expected wrap within 10 cycles"); end
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_lower = 8'd0; cfg_upper = 8'd2;
    #1;
    n_cmp++; if (wrap !== 1'b1 || cfg_ready !== 1'b1) begin n_bad++;
      $display("FAIL waw_write: got wrap=%b ready=%b expected 1/1", wrap, cfg_ready); end
    tick();
    set_idle();
    for (int k = 0; k < 6; k++) begin
      #1;
      n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++;
        $display("FAIL waw_pend_held: got %b expected 0", cfg_ready); end
      n_cmp++; if (out[0] !== 1'b0) begin n_bad++;
        $display("FAIL waw_not_applied: got %b expected 0", out[0]); end
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      #1;
      n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++;
        $display("FAIL waw_ready_after: got %b expected 1", cfg_ready); end
      n_cmp++; if (out !== m_out) begin n_bad++;
        $display("FAIL waw_out: got %b expected %b", out, m_out); end
      tick();
    end
  endtask

  task automatic test_small_period_hold();
    int hold;
    do_reset();
    enable = 1'b1;
    for (int p = 0; p < 2; p++) begin
      period = 8'(p);
      for (int k = 0; k < 5; k++) begin
        #1;
        n_cmp++; if (counter_out !== 8'd0 || wrap !== 1'b1) begin n_bad++;
          $display("FAIL small_period p=%0d: got cnt=%0d wrap=%b expected 0/1", p, counter_out,
                   wrap); end
        tick();
      end
    end
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_lower = 8'd0; cfg_upper = 8'd9;
    #1;
    tick();
    set_idle();
    period = 8'd10;
    repeat (4) begin #1; tick(); end
    enable = 1'b0;
    hold = m_cnt;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (counter_out !== W'(hold) || wrap !== 1'b0) begin n_bad++;
        $display("FAIL hold: got cnt=%0d wrap=%b expected %0d/0", counter_out, wrap, hold); end
      n_cmp++; if (out !== m_out) begin n_bad++;
        $display("FAIL hold_out: got %b expected %b", out, m_out); end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    period = 8'd7;
    for (int k = 0; k < 600; k++) begin
      reset      = ($urandom_range(99) == 0);
      enable     = ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0) period = 8'($urandom_range(15));
      cfg_valid  = ($urandom_range(2) == 0);
      cfg_ch     = 2'($urandom_range(3));
      cfg_lower  = 8'($urandom_range(15));
      cfg_upper  = 8'($urandom_range(15));
      cfg_invert = 1'($urandom_range(1));
      #1;
      n_cmp++; if (counter_out !== W'(m_cnt)) begin n_bad++;
        $display("FAIL rand_counter @%0d: got %0d expected %0d", k, counter_out, m_cnt); end
      n_cmp++; if (wrap !== m_wrap()) begin n_bad++;
        $display("FAIL rand_wrap @%0d: got %b expected %b", k, wrap, m_wrap()); end
      n_cmp++; if (cfg_ready !== m_ready()) begin n_bad++;
        $display("FAIL rand_ready @%0d: got %b expected %b", k, cfg_ready, m_ready()); end
      n_cmp++; if (out !== m_out) begin n_bad++;
        $display("FAIL rand_out @%0d: got %b expected %b", k, out, m_out); end
`ifdef WINDOW_PULSE_GEN_CFG_ERR_EN
      n_cmp++; if (cfg_err !== m_err) begin n_bad++;
        $display("FAIL rand_cfg_err @%0d: got %b expected %b", k, cfg_err, m_err); end
`endif
      tick();
    end
    reset = 1'b0;
  endtask

`ifdef WINDOW_PULSE_GEN_CFG_ERR_EN
  task automatic test_cfg_err();
    do_reset();
    enable = 1'b1; period = 8'd10;
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_lower = 8'd2; cfg_upper = 8'd5;
    #1;
    tick();
    set_idle();
    #1;
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++;
      $display("FAIL err_good_write: got %b expected 0", cfg_err); end
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_lower = 8'd7; cfg_upper = 8'd7;
    #1;
    tick();
    set_idle();
    for (int k = 0; k < 6; k++) begin
      #1;
      n_cmp++; if (cfg_err !== 1'b1) begin n_bad++;
        $display("FAIL err_equal_bounds: got %b expected 1", cfg_err); end
      tick();
    end
    do_reset();
    enable = 1'b1; period = 8'd10;
    #1;
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++;
      $display("FAIL err_cleared: got %b expected 0", cfg_err); end
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_lower = 8'd1; cfg_upper = 8'd12;
    #1;
    tick();
    set_idle();
    #1;
    n_cmp++; if (cfg_err !== 1'b1) begin n_bad++;
      $display("FAIL err_upper_ge_period: got %b expected 1", cfg_err); end
    tick();
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_window();
    test_invert();
    test_back_to_back();
    test_write_at_wrap();
    test_small_period_hold();
`ifdef WINDOW_PULSE_GEN_CFG_ERR_EN
    test_cfg_err();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
